alu_result_checker: RTL and testbench
=====================================

Name: alu_result_checker

Overview:
- Synthesizable checker on the response side of the 8-bit ALU stimulus interface (en, rst, a, b, MODO in; c out).
- Keeps a cycle-accurate reference model of the ALU output register and compares it against the DUT's c on every armed clock edge.
- Counts checks and errors, flags a sticky failure, and captures the first mismatch for debug.
- Sits beside the ALU in the bench top and in the FPGA self-test wrapper.

Parameters:
W, 8, operand/result width of a, b, c
CNT_W, 16, width of the check and error counters

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset of the checker itself
en  input  1  ALU enable as driven to the DUT
dut_rst  input  1  ALU reset as driven to the DUT
a  input  W  ALU operand A
b  input  W  ALU operand B
MODO  input  2  ALU operation select
c  input  W  DUT result under check
exp  output  W  reference model result
state  output  2  checker FSM state: 00 IDLE, 01 RUN, 10 FAIL
n_checks  output  CNT_W  number of comparisons performed
n_errors  output  CNT_W  number of mismatches
err_pulse  output  1  high for one cycle after a mismatching edge
fail  output  1  sticky mismatch flag
first_exp  output  W  expected value at first mismatch
first_got  output  W  c value at first mismatch
first_modo  output  2  MODO in effect when the mismatching result was produced

Behaviour:
- rst=1 (async): all outputs 0, state=IDLE.
- Reference model register m, visible on exp, updated each edge:
  - dut_rst=1: m<=0. dut_rst has priority over en; the DUT reset is modelled as synchronous.
  - else en=1: m<=f(a,b,MODO).
  - else: m holds.
- f truncates to W bits:
  - 00: a+b mod 2^W.
  - 01: a-b mod 2^W, two's complement wrap.
  - 10: low W bits of a*b.
  - 11: a<<b; result is 0 when b>=W.
- m_modo register: loads MODO whenever m loads from f; cleared by dut_rst.
- FSM:
  - IDLE: no compares. Goes to RUN on the first edge with en=1 or dut_rst=1 (the model is defined from that edge on).
  - RUN: compares on every edge, using c and m as they were just before the edge; both are registered, so both reflect the same prior edge. On mismatch, goes to FAIL.
  - FAIL: keeps comparing and counting; left only by rst.
- On each compare edge:
  - n_checks increments, saturating at 2^CNT_W-1.
  - On c!=m: n_errors increments (saturating) and err_pulse=1 for the following cycle; otherwise err_pulse=0.
  - Any X/Z bit in c counts as a mismatch (behavioural compare with !==).
- First-error capture:
  - On the RUN->FAIL edge, latch first_exp=m, first_got=c, first_modo=m_modo.
  - Later mismatches do not overwrite these; fail=1 from that edge until rst.
- The edge that moves IDLE->RUN performs no compare; the first compare happens on the next edge.
- Simultaneous dut_rst and en: the model clears. The next compare expects c=0.
- en=0 periods: the model holds and compares continue, so a DUT that changes c while disabled is an error.
- rst asserted mid-run: everything clears immediately, including captures and counters. Checking re-arms per the IDLE rule.
- Saturation: counters stick at the maximum value with no wrap. fail is unaffected by saturation.

Test Plan:
- Add: rst pulse, MODO=00, a=0x0A b=0x05 en=1 for 4 edges, correct DUT -> exp=0x0F, state RUN, n_checks=3, n_errors=0, fail=0. Then a=0x09 b=0x03 -> exp=0x0C.
- Sub/wrap: MODO=01, a=0x0A b=0x05 -> exp=0x05. Then a=0x03 b=0x05 -> exp=0xFE, no errors with correct DUT.
- Mult/shift: MODO=10, a=0x0A b=0x05 -> 0x32; a=0x09 b=0x03 -> 0x1B; a=0x10 b=0x10 -> 0x00. MODO=11, a=0x0A b=0x05 -> 0x40; a=0x09 b=0x03 -> 0x48; b=0x08 -> 0x00.
- Reset/hold: en=0 with dut_rst=1 for 4 edges -> exp=0, DUT c=0 gives no error. Then en=0 dut_rst=0 -> exp holds 0 and compares continue.
- Fault injection: force c=0x0E while exp=0x0F (MODO=00) -> err_pulse one cycle, n_errors=1, state FAIL, first_exp=0x0F, first_got=0x0E, first_modo=00. A second fault leaves the captures unchanged and sets n_errors=2.
- Async reset mid-FAIL: assert rst between edges -> all outputs 0 immediately and state=IDLE. The next en=1 edge arms the checker with no compare on that edge.

Source files
------------

// File: rtl/alu_result_checker.sv
// Response-side checker for the 8-bit ALU: keeps a cycle-accurate reference
// model of the ALU output register and compares the DUT result against it.
// Also keeps check and error counts, a sticky fail flag and first-mismatch capture.
module alu_result_checker #(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dut_rst,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [1:0]       MODO,
  input  logic [W-1:0]     c,
  output logic [W-1:0]     exp,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] n_checks,
  output logic [CNT_W-1:0] n_errors,
  output logic             err_pulse,
  output logic             fail,
  output logic [W-1:0]     first_exp,
  output logic [W-1:0]     first_got,
  output logic [1:0]       first_modo
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    FAIL_ST = 2'b10
  } state_t;

  localparam logic [W-1:0] SHIFT_LIMIT = W[W-1:0];

  // ALU function, truncated to W bits
  function automatic logic [W-1:0] alu_f(input logic [W-1:0] fa,
                                         input logic [W-1:0] fb,
                                         input logic [1:0]   fmodo);
    logic [2*W-1:0] prod;
    prod = {{W{1'b0}}, fa} * {{W{1'b0}}, fb};
    case (fmodo)
      2'b00:   alu_f = fa + fb;
      2'b01:   alu_f = fa - fb;
      2'b10:   alu_f = prod[W-1:0];
      default: alu_f = (fb >= SHIFT_LIMIT) ? '0 : (fa << fb);
    endcase
  endfunction

  // Saturating increment: counters stick at all-ones
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  state_t           state_q, state_d;
  logic [W-1:0]     m_q, m_d;
  logic [1:0]       m_modo_q, m_modo_d;
  logic [CNT_W-1:0] n_checks_q, n_checks_d;
  logic [CNT_W-1:0] n_errors_q, n_errors_d;
  logic             err_pulse_q, err_pulse_d;
  logic             fail_q, fail_d;
  logic [W-1:0]     first_exp_q, first_exp_d;
  logic [W-1:0]     first_got_q, first_got_d;
  logic [1:0]       first_modo_q, first_modo_d;
  logic             mismatch;
  logic             do_cmp;

  // Reference model, FSM next state, counters and first-error capture
  always_comb begin
    state_d      = state_q;
    m_d          = m_q;
    m_modo_d     = m_modo_q;
    n_checks_d   = n_checks_q;
    n_errors_d   = n_errors_q;
    err_pulse_d  = 1'b0;
    fail_d       = fail_q;
    first_exp_d  = first_exp_q;
    first_got_d  = first_got_q;
    first_modo_d = first_modo_q;
    do_cmp       = 1'b0;
    // X/Z bits on c must count as a mismatch, hence the case inequality
    mismatch     = (c !== m_q);

    // DUT reset is synchronous and wins over enable
    if (dut_rst) begin
      m_d      = '0;
      m_modo_d = 2'b00;
    end else if (en) begin
      m_d      = alu_f(a, b, MODO);
      m_modo_d = MODO;
    end

    case (state_q)
      IDLE: begin
        if (en || dut_rst) state_d = RUN;
      end
      RUN:     do_cmp = 1'b1;
      FAIL_ST: do_cmp = 1'b1;
      default: state_d = IDLE;
    endcase

    if (do_cmp) begin
      n_checks_d = sat_inc(n_checks_q);
      if (mismatch) begin
        n_errors_d  = sat_inc(n_errors_q);
        err_pulse_d = 1'b1;
        if (state_q == RUN) begin
          state_d      = FAIL_ST;
          fail_d       = 1'b1;
          first_exp_d  = m_q;
          first_got_d  = c;
          first_modo_d = m_modo_q;
        end
      end
    end
  end

  // State registers with asynchronous checker reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      m_q          <= '0;
      m_modo_q     <= 2'b00;
      n_checks_q   <= '0;
      n_errors_q   <= '0;
      err_pulse_q  <= 1'b0;
      fail_q       <= 1'b0;
      first_exp_q  <= '0;
      first_got_q  <= '0;
      first_modo_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      m_q          <= m_d;
      m_modo_q     <= m_modo_d;
      n_checks_q   <= n_checks_d;
      n_errors_q   <= n_errors_d;
      err_pulse_q  <= err_pulse_d;
      fail_q       <= fail_d;
      first_exp_q  <= first_exp_d;
      first_got_q  <= first_got_d;
      first_modo_q <= first_modo_d;
    end
  end

  assign exp        = m_q;
  assign state      = state_q;
  assign n_checks   = n_checks_q;
  assign n_errors   = n_errors_q;
  assign err_pulse  = err_pulse_q;
  assign fail       = fail_q;
  assign first_exp  = first_exp_q;
  assign first_got  = first_got_q;
  assign first_modo = first_modo_q;

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed testbench for alu_result_checker. The bench plays the part of a
// correct ALU by driving c with hand-computed results, then injects faults.
module tb_alu_result_checker;

  localparam int W     = 8;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             en;
  logic             dut_rst;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic [1:0]       modo;
  logic [W-1:0]     c;
  logic [W-1:0]     exp_o;
  logic [1:0]       state;
  logic [CNT_W-1:0] n_checks;
  logic [CNT_W-1:0] n_errors;
  logic             err_pulse;
  logic             fail;
  logic [W-1:0]     first_exp;
  logic [W-1:0]     first_got;
  logic [1:0]       first_modo;

  int checks = 0;
  int errors = 0;
  int exp_chk = 0;
  bit armed = 1'b0;

  alu_result_checker #(.W(W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .dut_rst    (dut_rst),
    .a          (a),
    .b          (b),
    .MODO       (modo),
    .c          (c),
    .exp        (exp_o),
    .state      (state),
    .n_checks   (n_checks),
    .n_errors   (n_errors),
    .err_pulse  (err_pulse),
    .fail       (fail),
    .first_exp  (first_exp),
    .first_got  (first_got),
    .first_modo (first_modo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // One clock edge; inputs stay stable across it and outputs are sampled 1ns later.
  // exp_chk tracks how many compares the checker should have made (saturating).
  task automatic tick();
    @(posedge clk);
    if (armed && exp_chk < 255) exp_chk++;
    if (en || dut_rst) armed = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; dut_rst = 1'b0; a = '0; b = '0; modo = 2'b00; c = '0;
    armed = 1'b0; exp_chk = 0;
    tick();
    tick();
    checks++;
    if ({exp_o, state, n_checks, n_errors, err_pulse, fail} !== '0) begin
      errors++;
      $display("FAIL reset_main got exp=%h state=%b chk=%0d err=%0d pulse=%b fail=%b want all 0",
               exp_o, state, n_checks, n_errors, err_pulse, fail);
    end
    checks++;
    if ({first_exp, first_got, first_modo} !== '0) begin
      errors++;
      $display("FAIL reset_capture got %h %h %b want 0", first_exp, first_got, first_modo);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (state !== 2'b00 || n_checks !== 8'd0) begin
      errors++;
      $display("FAIL idle_no_arm got state=%b chk=%0d want 00/0", state, n_checks);
    end
  endtask

  task automatic test_add();
    modo = 2'b00; a = 8'h0A; b = 8'h05; en = 1'b1; dut_rst = 1'b0; c = '0;
    tick();
    c = 8'h0F;
    tick();
    tick();
    tick();
    checks++;
    if (exp_o !== 8'h0F) begin
      errors++; $display("FAIL add_exp got %h want 0f", exp_o);
    end
    checks++;
    if (state !== 2'b01) begin
      errors++; $display("FAIL add_state got %b want 01", state);
    end
    checks++;
    if (n_checks !== 8'd3) begin
      errors++; $display("FAIL add_nchecks got %0d want 3", n_checks);
    end
    checks++;
    if (n_errors !== 8'd0 || fail !== 1'b0) begin
      errors++; $display("FAIL add_clean got err=%0d fail=%b want 0/0", n_errors, fail);
    end
    a = 8'h09; b = 8'h03;
    tick();
    checks++;
    if (exp_o !== 8'h0C) begin
      errors++; $display("FAIL add2_exp got %h want 0c", exp_o);
    end
    c = 8'h0C;
    tick();
  endtask

  task automatic test_sub();
    modo = 2'b01; a = 8'h0A; b = 8'h05;
    tick();
    checks++;
    if (exp_o !== 8'h05) begin
      errors++; $display("FAIL sub_exp got %h want 05", exp_o);
    end
    c = 8'h05;
    a = 8'h03; b = 8'h05;
    tick();
    checks++;
    if (exp_o !== 8'hFE) begin
      errors++; $display("FAIL sub_wrap_exp got %h want fe", exp_o);
    end
    c = 8'hFE;
    tick();
    checks++;
    if (n_errors !== 8'd0 || n_checks !== exp_chk[7:0]) begin
      errors++;
      $display("FAIL sub_counts got err=%0d chk=%0d want 0/%0d", n_errors, n_checks, exp_chk);
    end
  endtask

  task automatic test_mul_shift();
    logic [1:0] vm [6];
    logic [7:0] va [6];
    logic [7:0] vb [6];
    logic [7:0] vr [6];
    vm = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11};
    va = '{8'h0A, 8'h09, 8'h10, 8'h0A, 8'h09, 8'h09};
    vb = '{8'h05, 8'h03, 8'h10, 8'h05, 8'h03, 8'h08};
    vr = '{8'h32, 8'h1B, 8'h00, 8'h40, 8'h48, 8'h00};
    for (int i = 0; i < 6; i++) begin
      modo = vm[i]; a = va[i]; b = vb[i];
      tick();
      checks++;
      if (exp_o !== vr[i]) begin
        errors++;
        $display("FAIL mulshift_%0d got %h want %h", i, exp_o, vr[i]);
      end
      c = vr[i];
    end
    tick();
    checks++;
    if (n_errors !== 8'd0 || fail !== 1'b0) begin
      errors++; $display("FAIL mulshift_clean got err=%0d fail=%b want 0/0", n_errors, fail);
    end
  endtask

  task automatic test_reset_hold();
    modo = 2'b00; a = 8'h22; b = 8'h11; en = 1'b1; dut_rst = 1'b1;
    tick();
    checks++;
    if (exp_o !== 8'h00) begin
      errors++; $display("FAIL rst_en_prio got %h want 00", exp_o);
    end
    c = 8'h00;
    en = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (exp_o !== 8'h00 || n_errors !== 8'd0) begin
      errors++; $display("FAIL dutrst_hold got exp=%h err=%0d want 00/0", exp_o, n_errors);
    end
    dut_rst = 1'b0; a = 8'hFF; b = 8'hFF;
    tick();
    tick();
    checks++;
    if (exp_o !== 8'h00 || n_errors !== 8'd0 || state !== 2'b01) begin
      errors++;
      $display("FAIL disabled_hold got exp=%h err=%0d state=%b want 00/0/01", exp_o, n_errors, state);
    end
    checks++;
    if (n_checks !== exp_chk[7:0]) begin
      errors++; $display("FAIL disabled_nchecks got %0d want %0d", n_checks, exp_chk);
    end
  endtask

  task automatic test_fault();
    modo = 2'b00; a = 8'h0A; b = 8'h05; en = 1'b1;
    tick();
    c = 8'h0E;
    tick();
    checks++;
    if (err_pulse !== 1'b1 || n_errors !== 8'd1) begin
      errors++; $display("FAIL fault1_err got pulse=%b err=%0d want 1/1", err_pulse, n_errors);
    end
    checks++;
    if (state !== 2'b10 || fail !== 1'b1) begin
      errors++; $display("FAIL fault1_state got state=%b fail=%b want 10/1", state, fail);
    end
    checks++;
    if (first_exp !== 8'h0F || first_got !== 8'h0E || first_modo !== 2'b00) begin
      errors++;
      $display("FAIL fault1_capture got %h/%h/%b want 0f/0e/00", first_exp, first_got, first_modo);
    end
    c = 8'h0F;
    modo = 2'b01;
    tick();
    checks++;
    if (err_pulse !== 1'b0 || n_errors !== 8'd1 || state !== 2'b10) begin
      errors++;
      $display("FAIL pulse_clear got pulse=%b err=%0d state=%b want 0/1/10", err_pulse, n_errors, state);
    end
    c = 8'h11;
    tick();
    checks++;
    if (n_errors !== 8'd2 || err_pulse !== 1'b1) begin
      errors++; $display("FAIL fault2_err got err=%0d pulse=%b want 2/1", n_errors, err_pulse);
    end
    checks++;
    if (first_exp !== 8'h0F || first_got !== 8'h0E || first_modo !== 2'b00 || fail !== 1'b1) begin
      errors++;
      $display("FAIL fault2_capture got %h/%h/%b fail=%b want 0f/0e/00/1",
               first_exp, first_got, first_modo, fail);
    end
  endtask

  task automatic test_xz_saturation();
    c = 8'h05;
    tick();
    c = 'x;
    tick();
    checks++;
    if (n_errors !== 8'd3 || err_pulse !== 1'b1) begin
      errors++; $display("FAIL xz_mismatch got err=%0d pulse=%b want 3/1", n_errors, err_pulse);
    end
    c = 8'hAA;
    for (int i = 0; i < 300; i++) tick();
    checks++;
    if (n_checks !== 8'd255 || n_errors !== 8'd255) begin
      errors++; $display("FAIL saturate got chk=%0d err=%0d want 255/255", n_checks, n_errors);
    end
    checks++;
    if (fail !== 1'b1 || state !== 2'b10 || first_got !== 8'h0E) begin
      errors++;
      $display("FAIL saturate_sticky got fail=%b state=%b first_got=%h want 1/10/0e",
               fail, state, first_got);
    end
  endtask

  task automatic test_async_reset();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({exp_o, state, n_checks, n_errors, err_pulse, fail} !== '0) begin
      errors++;
      $display("FAIL async_rst_main got exp=%h state=%b chk=%0d err=%0d pulse=%b fail=%b want all 0",
               exp_o, state, n_checks, n_errors, err_pulse, fail);
    end
    checks++;
    if ({first_exp, first_got, first_modo} !== '0) begin
      errors++;
      $display("FAIL async_rst_capture got %h %h %b want 0", first_exp, first_got, first_modo);
    end
    #1;
    rst = 1'b0;
    armed = 1'b0; exp_chk = 0;
    modo = 2'b00; a = 8'h01; b = 8'h01; en = 1'b1; dut_rst = 1'b0; c = 8'h55;
    tick();
    checks++;
    if (state !== 2'b01 || n_checks !== 8'd0 || n_errors !== 8'd0 || exp_o !== 8'h02) begin
      errors++;
      $display("FAIL rearm got state=%b chk=%0d err=%0d exp=%h want 01/0/0/02",
               state, n_checks, n_errors, exp_o);
    end
    c = 8'h02;
    tick();
    checks++;
    if (n_checks !== 8'd1 || n_errors !== 8'd0 || fail !== 1'b0) begin
      errors++;
      $display("FAIL rearm_first_cmp got chk=%0d err=%0d fail=%b want 1/0/0", n_checks, n_errors, fail);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mul_shift();
    test_reset_hold();
    test_fault();
    test_xz_saturation();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
